// File: rtl/serial_alu_w.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_w
// Purpose  : Digit-serial ALU. Operands arrive LSB-first, DIGIT bits per
//            beat, over N = XLEN/DIGIT beats. Arithmetic and bitwise ops
//            stream a result digit back per beat; compare ops (SLT, SLTU,
//            EQ) produce a single o_cmp bit at the end. EQ may optionally
//            terminate on the first mismatching digit.
//
// Ports    : clk         - clock, rising edge
//            reset       - asynchronous, active-low reset
//            i_start     - start request, accepted only while o_ready=1
//            i_op        - opcode, sampled with the accepted i_start
//                          0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR,
//                          5 SLT, 6 SLTU, 7 EQ, 8-15 NOP
//            i_en        - an operand digit is present on i_a/i_b
//            i_a, i_b    - operand digits, LSB-first
//            o_ready     - idle, i_start can be accepted
//            o_take      - current i_a/i_b digit is consumed at this edge
//            o_rd        - registered result digit, LSB-first
//            o_rd_valid  - o_rd carries a valid digit
//            o_cmp       - compare result, valid from o_done until the
//                          next accepted i_start
//            o_done      - one-cycle pulse, operation complete
//            o_early     - with o_done: ended before all N digits taken
//
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_w #(
  parameter int XLEN     = 32,
  parameter int DIGIT    = 1,
  parameter bit EARLY_EQ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic             i_en,
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_ready,
  output logic             o_take,
  output logic [DIGIT-1:0] o_rd,
  output logic             o_rd_valid,
  output logic             o_cmp,
  output logic             o_done,
  output logic             o_early
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int            c_N    = XLEN / DIGIT;
  localparam int            c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_XOR  = 4'd2;
  localparam logic [3:0] c_OP_AND  = 4'd3;
  localparam logic [3:0] c_OP_OR   = 4'd4;
  localparam logic [3:0] c_OP_SLT  = 4'd5;
  localparam logic [3:0] c_OP_SLTU = 4'd6;
  localparam logic [3:0] c_OP_EQ   = 4'd7;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity check
  // --------------------------------------------------------------------------
  generate
    if (((XLEN % DIGIT) != 0) ||
        !((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4) || (DIGIT == 8))) begin : g_bad_params
      $error("serial_alu_w: DIGIT must be 1, 2, 4 or 8 and divide XLEN");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_op;
  logic [c_CW-1:0]   r_cnt;
  logic              r_carry;
  logic              r_eq_ok;
  logic [DIGIT-1:0]  r_rd;
  logic              r_rd_valid;
  logic              r_cmp;
  logic              r_done;
  logic              r_early;

  // --------------------------------------------------------------------------
  // Per-beat datapath
  // --------------------------------------------------------------------------
  logic              w_take;
  logic              w_last;
  logic              w_inv_b;
  logic              w_start_inv;
  logic              w_data_op;
  logic              w_match;
  logic              w_eq_stop;
  logic              w_cmp_final;
  logic [DIGIT-1:0]  w_b_eff;
  logic [DIGIT-1:0]  w_res;
  logic [DIGIT:0]    w_sum;

  assign w_take = (r_state == ST_RUN) & i_en;
  assign w_last = (r_cnt == c_LAST);

  always_comb begin
    // Subtract-style ops run a + ~b with the carry preset to 1 at accept.
    w_inv_b     = (r_op == c_OP_SUB) | (r_op == c_OP_SLT) | (r_op == c_OP_SLTU);
    w_start_inv = (i_op == c_OP_SUB) | (i_op == c_OP_SLT) | (i_op == c_OP_SLTU);
    // Only ADD/SUB/XOR/AND/OR stream result digits.
    w_data_op   = (r_op < c_OP_SLT);
    w_match     = (i_a == i_b);
    w_eq_stop   = EARLY_EQ & (r_op == c_OP_EQ) & ~w_match;

    w_b_eff = w_inv_b ? ~i_b : i_b;
    w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{DIGIT{1'b0}}, r_carry};

    w_res = '0;
    case (r_op)
      c_OP_ADD,
      c_OP_SUB: w_res = w_sum[DIGIT-1:0];
      c_OP_XOR: w_res = i_a ^ i_b;
      c_OP_AND: w_res = i_a & i_b;
      c_OP_OR:  w_res = i_a | i_b;
      default:  w_res = '0;
    endcase

    // Compare outcome, meaningful only on the final digit.
    w_cmp_final = 1'b0;
    case (r_op)
      // Unsigned a < b exactly when a - b borrows, i.e. no carry out.
      c_OP_SLTU: w_cmp_final = ~w_sum[DIGIT];
      // Differing signs decide directly; equal signs cannot overflow, so
      // the sign of the difference is the answer.
      c_OP_SLT:  w_cmp_final = (i_a[DIGIT-1] != i_b[DIGIT-1]) ? i_a[DIGIT-1]
                                                               : w_sum[DIGIT-1];
      c_OP_EQ:   w_cmp_final = r_eq_ok & w_match;
      default:   w_cmp_final = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= 4'd0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_eq_ok    <= 1'b0;
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
      r_cmp      <= 1'b0;
      r_done     <= 1'b0;
      r_early    <= 1'b0;
    end else begin
      // Pulse-style outputs default low every cycle.
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_early    <= 1'b0;

      if (r_state == ST_IDLE) begin
        // The o_done cycle is already IDLE, so back-to-back starts work.
        if (i_start) begin
          r_state <= ST_RUN;
          r_op    <= i_op;
          r_cnt   <= '0;
          r_carry <= w_start_inv;
          r_eq_ok <= 1'b1;
          r_cmp   <= 1'b0;
        end
      end else begin
        // Stalled beats (i_en=0) leave counter, carry and o_rd untouched.
        if (i_en) begin
          r_cnt   <= r_cnt + c_CW'(1);
          r_carry <= w_sum[DIGIT];
          r_eq_ok <= r_eq_ok & w_match;

          if (w_data_op) begin
            r_rd       <= w_res;
            r_rd_valid <= 1'b1;
          end

          if (w_last || w_eq_stop) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_cmp   <= w_eq_stop ? 1'b0 : w_cmp_final;
            // A mismatch on the very last digit consumed all N digits,
            // so it is not an early finish.
            r_early <= w_eq_stop & ~w_last;
          end
        end
      end
    end
  end

  assign o_ready    = (r_state == ST_IDLE);
  assign o_take     = w_take;
  assign o_rd       = r_rd;
  assign o_rd_valid = r_rd_valid;
  assign o_cmp      = r_cmp;
  assign o_done     = r_done;
  assign o_early    = r_early;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_w.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_w
// Purpose  : Directed self-checking bench for serial_alu_w. Two instances
//            share clock and reset: DIGIT=1 with early EQ, DIGIT=4 without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_w;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_NOP  = 4'd12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       i_start1, i_en1;
  logic [3:0] i_op1;
  logic [0:0] i_a1, i_b1, o_rd1;
  logic       o_ready1, o_take1, o_rd_valid1, o_cmp1, o_done1, o_early1;

  logic       i_start4, i_en4;
  logic [3:0] i_op4;
  logic [3:0] i_a4, i_b4, o_rd4;
  logic       o_ready4, o_take4, o_rd_valid4, o_cmp4, o_done4, o_early4;

  serial_alu_w #(.XLEN(32), .DIGIT(1), .EARLY_EQ(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .i_start(i_start1), .i_op(i_op1), .i_en(i_en1),
    .i_a(i_a1), .i_b(i_b1), .o_ready(o_ready1), .o_take(o_take1), .o_rd(o_rd1),
    .o_rd_valid(o_rd_valid1), .o_cmp(o_cmp1), .o_done(o_done1), .o_early(o_early1)
  );

  serial_alu_w #(.XLEN(32), .DIGIT(4), .EARLY_EQ(1'b0)) u_dut4 (
    .clk(clk), .reset(reset), .i_start(i_start4), .i_op(i_op4), .i_en(i_en4),
    .i_a(i_a4), .i_b(i_b4), .o_ready(o_ready4), .o_take(o_take4), .o_rd(o_rd4),
    .o_rd_valid(o_rd_valid4), .o_cmp(o_cmp4), .o_done(o_done4), .o_early(o_early4)
  );

  // Instance selector used by the generic operation driver.
  logic sel4 = 1'b0;
  wire  ready_m = sel4 ? o_ready4    : o_ready1;
  wire  take_m  = sel4 ? o_take4     : o_take1;
  wire  vld_m   = sel4 ? o_rd_valid4 : o_rd_valid1;
  wire  cmp_m   = sel4 ? o_cmp4      : o_cmp1;
  wire  done_m  = sel4 ? o_done4     : o_done1;
  wire  early_m = sel4 ? o_early4    : o_early1;

  int n_checks = 0;
  int n_pass   = 0;

  // Starts an op on the selected instance (called while it is idle, which
  // includes the o_done cycle) and feeds digits until o_done or a timeout.
  task automatic run_op(input logic use4, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit toggle,
                        output logic [31:0] res, output int nvalid, output int ntakes,
                        output int cyc, output logic cmp, output logic early,
                        output bit tmo, output bit acc_ok);
    int   idx;
    bit   fin;
    logic tk;
    logic en;
    sel4 = use4;
    res = '0; nvalid = 0; ntakes = 0; cyc = 0; cmp = 1'b0; early = 1'b0;
    tmo = 1'b0; acc_ok = 1'b0; idx = 0; fin = 1'b0;
    if (use4) begin i_start4 = 1'b1; i_op4 = op; i_en4 = 1'b0; end
    else      begin i_start1 = 1'b1; i_op1 = op; i_en1 = 1'b0; end
    @(posedge clk); #1;
    acc_ok   = (ready_m == 1'b0);
    i_start1 = 1'b0;
    i_start4 = 1'b0;
    while (!fin && cyc < 200) begin
      en = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (use4) begin
        i_en4 = en;
        i_a4  = (idx < 8) ? a[idx*4 +: 4] : 4'h0;
        i_b4  = (idx < 8) ? b[idx*4 +: 4] : 4'h0;
      end else begin
        i_en1 = en;
        i_a1  = (idx < 32) ? a[idx] : 1'b0;
        i_b1  = (idx < 32) ? b[idx] : 1'b0;
      end
      #1;
      tk = take_m;
      @(posedge clk); #1;
      cyc++;
      if (tk) begin idx++; ntakes++; end
      if (vld_m) begin
        if (use4) begin if (nvalid < 8)  res[nvalid*4 +: 4] = o_rd4; end
        else      begin if (nvalid < 32) res[nvalid] = o_rd1[0]; end
        nvalid++;
      end
      if (done_m) begin
        cmp   = cmp_m;
        early = early_m;
        fin   = 1'b1;
      end
    end
    i_en1 = 1'b0;
    i_en4 = 1'b0;
    tmo   = !fin;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_start1 = 1'b0; i_start4 = 1'b0; i_op1 = 4'd0; i_op4 = 4'd0;
    i_en1 = 1'b1; i_en4 = 1'b1;
    i_a1 = 1'b0; i_b1 = 1'b0; i_a4 = 4'h0; i_b4 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_ready1, o_take1, o_rd1, o_rd_valid1, o_cmp1, o_done1, o_early1} !== 7'b1000000)
      $display("FAIL reset_dut1: outputs got %b expected 1000000",
               {o_ready1, o_take1, o_rd1, o_rd_valid1, o_cmp1, o_done1, o_early1});
    else n_pass++;
    n_checks++;
    if ({o_ready4, o_take4, o_rd4, o_rd_valid4, o_cmp4, o_done4, o_early4} !== 10'b1000000000)
      $display("FAIL reset_dut4: outputs got %b expected 1000000000",
               {o_ready4, o_take4, o_rd4, o_rd_valid4, o_cmp4, o_done4, o_early4});
    else n_pass++;
    i_en1 = 1'b0; i_en4 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (tmo !== 1'b0 || acc !== 1'b1) $display("FAIL add1_handshake: timeout %0b accepted %0b expected 0 1", tmo, acc);
    else n_pass++;
    n_checks++;
    if (res !== 32'h0 || nv !== 32) $display("FAIL add1_result: got %h (%0d digits) expected 00000000 (32 digits)", res, nv);
    else n_pass++;
    n_checks++;
    if (cy !== 32 || early !== 1'b0) $display("FAIL add1_latency: done after %0d edges early %0b expected 32 0", cy, early);
    else n_pass++;
    @(posedge clk); #1;
    run_op(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (res !== 32'h8000_0000 || nv !== 8 || cy !== 8)
      $display("FAIL add4_result: got %h (%0d digits, %0d edges) expected 80000000 (8, 8)", res, nv, cy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_sub_stall();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b1, OP_SUB, 32'd5, 32'd7, 1'b1, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (res !== 32'hFFFF_FFFE || nv !== 8) $display("FAIL sub4_result: got %h (%0d digits) expected fffffffe (8)", res, nv);
    else n_pass++;
    n_checks++;
    if (nt !== 8 || cy !== 15) $display("FAIL sub4_stall: takes %0d edges %0d expected 8 15", nt, cy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_logic();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b1, OP_OR, 32'h1234_0000, 32'h0000_5678, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (res !== 32'h1234_5678 || nv !== 8) $display("FAIL or4_result: got %h (%0d digits) expected 12345678 (8)", res, nv);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_compare();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b0, OP_SLT, 32'h8000_0000, 32'h0000_0001, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (cmp !== 1'b1 || nv !== 0 || tmo !== 1'b0) $display("FAIL slt1_neg: cmp %0b valid digits %0d expected 1 0", cmp, nv);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_cmp1 !== 1'b1) $display("FAIL slt1_hold: o_cmp got %0b expected 1", o_cmp1);
    else n_pass++;
    run_op(1'b0, OP_SLTU, 32'h8000_0000, 32'h0000_0001, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (cmp !== 1'b0 || nv !== 0) $display("FAIL sltu1: cmp %0b valid digits %0d expected 0 0", cmp, nv);
    else n_pass++;
    @(posedge clk); #1;
    run_op(1'b1, OP_SLT, 32'd3, 32'd5, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (cmp !== 1'b1 || cy !== 8) $display("FAIL slt4_pos: cmp %0b edges %0d expected 1 8", cmp, cy);
    else n_pass++;
    @(posedge clk); #1;
    run_op(1'b1, OP_SLTU, 32'd9, 32'd5, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (cmp !== 1'b0) $display("FAIL sltu4_ge: cmp got %0b expected 0", cmp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_eq();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b0, OP_EQ, 32'h1234_5678, 32'h1234_5679, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (nt !== 1 || cy !== 1 || cmp !== 1'b0 || early !== 1'b1)
      $display("FAIL eq1_early: takes %0d edges %0d cmp %0b early %0b expected 1 1 0 1", nt, cy, cmp, early);
    else n_pass++;
    @(posedge clk); #1;
    run_op(1'b0, OP_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (nt !== 32 || cmp !== 1'b1 || early !== 1'b0 || nv !== 0)
      $display("FAIL eq1_equal: takes %0d cmp %0b early %0b digits %0d expected 32 1 0 0", nt, cmp, early, nv);
    else n_pass++;
    @(posedge clk); #1;
    run_op(1'b1, OP_EQ, 32'h1234_5678, 32'h1234_5679, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (nt !== 8 || cmp !== 1'b0 || early !== 1'b0)
      $display("FAIL eq4_noearly: takes %0d cmp %0b early %0b expected 8 0 0", nt, cmp, early);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_nop();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b1, OP_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (tmo !== 1'b0 || cy !== 8 || nv !== 0 || cmp !== 1'b0)
      $display("FAIL nop4: timeout %0b edges %0d digits %0d cmp %0b expected 0 8 0 0", tmo, cy, nv, cmp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    run_op(1'b1, OP_XOR, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (res !== 32'hFF00_5A5A || nv !== 8) $display("FAIL b2b_xor: got %h (%0d digits) expected ff005a5a (8)", res, nv);
    else n_pass++;
    n_checks++;
    if (o_done4 !== 1'b1 || o_ready4 !== 1'b1) $display("FAIL b2b_done_ready: done %0b ready %0b expected 1 1", o_done4, o_ready4);
    else n_pass++;
    run_op(1'b1, OP_AND, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (acc !== 1'b1 || res !== 32'h0204_0608 || cy !== 8)
      $display("FAIL b2b_and: accepted %0b got %h edges %0d expected 1 02040608 8", acc, res, cy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] a;
    logic [31:0] res; int nv, nt, cy; logic cmp, early; bit tmo, acc;
    bit saw_done;
    a = 32'h0000_FFFF;
    sel4 = 1'b0;
    i_start1 = 1'b1; i_op1 = OP_ADD;
    @(posedge clk); #1;
    i_start1 = 1'b0;
    i_en1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_a1 = a[k]; i_b1 = (k == 0) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({o_ready1, o_take1, o_rd1, o_rd_valid1, o_cmp1, o_done1, o_early1} !== 7'b1000000)
      $display("FAIL midrun_reset: outputs got %b expected 1000000",
               {o_ready1, o_take1, o_rd1, o_rd_valid1, o_cmp1, o_done1, o_early1});
    else n_pass++;
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (o_done1 === 1'b1) saw_done = 1'b1;
    end
    i_en1 = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done1 === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL midrun_no_done: saw o_done %0b expected 0", saw_done);
    else n_pass++;
    run_op(1'b0, OP_ADD, 32'd3, 32'd4, 1'b0, res, nv, nt, cy, cmp, early, tmo, acc);
    n_checks++;
    if (res !== 32'd7 || nv !== 32 || cy !== 32)
      $display("FAIL post_reset_add: got %h (%0d digits, %0d edges) expected 00000007 (32, 32)", res, nv, cy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_stall();
    test_logic();
    test_compare();
    test_eq();
    test_nop();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_alu_w.md
SERIAL_ALU_W -- requirements
Module: serial_alu_w

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 1, bits processed per beat; legal values 1, 2, 4, 8.
REQ-003 Parameter EARLY_EQ, default 1, enables early termination of EQ on first mismatching digit.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  start request; accepted only while o_ready=1.
REQ-007 i_op  in  4  opcode, sampled with accepted i_start: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR, 5 SLT, 6 SLTU, 7 EQ, 8-15 NOP.
REQ-008 i_en  in  1  operand digit present on i_a/i_b this cycle.
REQ-009 i_a, i_b  in  DIGIT  operand digits, LSB-first.
REQ-010 o_ready  out  1  block idle, can accept i_start.
REQ-011 o_take  out  1  combinational, =1 when the current i_a/i_b digit is consumed this edge.
REQ-012 o_rd  out  DIGIT  registered result digit, LSB-first.
REQ-013 o_rd_valid  out  1  o_rd carries a valid digit.
REQ-014 o_cmp  out  1  compare result; valid from o_done until next accepted i_start.
REQ-015 o_done  out  1  one-cycle pulse, operation complete.
REQ-016 o_early  out  1  with o_done: operation ended before N=XLEN/DIGIT digits were consumed.

Function
REQ-017 FSM states IDLE, RUN; IDLE->RUN on i_start, RUN->IDLE on final take or early stop.
REQ-018 o_ready=1 exactly in IDLE; i_start in RUN SHALL be ignored; i_op latched at accept.
REQ-019 Beat counter SHALL clear at accept and increment only on o_take; width ceil(log2(N)), N=XLEN/DIGIT.
REQ-020 o_take = RUN & i_en; i_en=0 stalls: counter, carry and outputs hold, o_rd_valid=0.
REQ-021 ADD: o_rd = a+b+carry per digit; carry register cleared at accept, carry-out of MSB digit discarded (mod 2^XLEN).
REQ-022 SUB: a+~b with carry preset to 1 at accept; result mod 2^XLEN.
REQ-023 XOR/AND/OR: bitwise per digit, no carry state.
REQ-024 ADD/SUB/XOR/AND/OR: o_rd_valid=1 on cycle after each take, N pulses total.
REQ-025 SLT/SLTU/EQ/NOP: o_rd_valid SHALL stay 0.
REQ-026 SLTU: internal a+~b+1; o_cmp = ~carry-out of final digit.
REQ-027 SLT: o_cmp = a_msb if a_msb!=b_msb, else MSB of difference.
REQ-028 EQ: o_cmp=1 iff all N digit pairs equal.
REQ-029 EQ with EARLY_EQ=1: first mismatching take ends op; o_done next cycle, o_cmp=0, o_early=1; producer discards the remaining digits.
REQ-030 EQ with EARLY_EQ=0, and all other ops: o_early=0, exactly N takes.
REQ-031 NOP: consumes N digits, o_cmp=0, o_done asserted.
REQ-032 o_done SHALL pulse the cycle after final take, coincident with last o_rd_valid; o_ready=1 same cycle.
REQ-033 i_start asserted in the o_done cycle SHALL be accepted (back-to-back, no idle gap).
REQ-034 Latency with i_en continuously 1: accept at edge 0, takes at edges 1..N, o_done high after edge N.

Reset
REQ-035 reset=0 SHALL immediately force IDLE, o_ready=1, o_take=0, o_rd=0, o_rd_valid=0, o_cmp=0, o_done=0, o_early=0, counter=0, carry=0.
REQ-036 reset mid-RUN SHALL abort the op without o_done; the first op after release behaves as from clean reset.

Verification
REQ-037 XLEN=32,DIGIT=1, ADD 0xFFFFFFFF+1, i_en=1 -> 32 o_rd_valid digits, all 0; o_done after edge 32.
REQ-038 DIGIT=4, SUB 5-7 with i_en toggling 1,0 -> result 0xFFFFFFFE, 8 digits, stalls add 1 cycle each.
REQ-039 SLT 0x80000000 vs 1 -> o_cmp=1; SLTU same operands -> o_cmp=0; no o_rd_valid.
REQ-040 EQ 0x12345678 vs 0x12345679, DIGIT=1, EARLY_EQ=1 -> mismatch at beat 0, o_done after 1 take, o_cmp=0, o_early=1.
REQ-041 Back-to-back XOR then AND, i_start in o_done cycle -> second op starts with no gap, correct results both.
REQ-042 reset pulse at beat 10 of ADD -> no o_done, outputs zeroed; subsequent ADD 3+4 -> 7.
